ps2_scancode_decoder: RTL
=========================

Name: ps2_scancode_decoder

Overview:
Downstream consumer of the PS/2 keyboard receiver FIFO. Pops raw Set-2 scan-code bytes through the receiver's ready/nextdata_n interface and strips the E0/F0/E1 prefixes. Tracks modifier state and emits one decoded key event per make/break, with ASCII translation, on a valid/ready handshake. That handshake feeds the keyboard MMIO register on the peripheral bus.

Parameters:
E1_SKIP_LEN, 7, number of bytes discarded after an E1 (Pause) prefix
ASCII_EN, 1, 1 = drive evt_ascii from the map; 0 = tie evt_ascii to 0

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
kbd_scan_code  input  8  byte at head of receiver FIFO (combinational from receiver)
kbd_ready  input  1  receiver FIFO non-empty
kbd_nextdata_n  output  1  active-low pop strobe to receiver, one cycle per byte
evt_valid  output  1  decoded event held in output register
evt_ready  input  1  downstream accepts event
evt_code  output  8  scan code with prefixes removed
evt_ext  output  1  event was E0-prefixed
evt_break  output  1  1 = key release, 0 = key press/repeat
evt_ascii  output  8  ASCII for make events of printable keys, else 0x00
evt_mods  output  4  {caps_lock, alt, ctrl, shift} after applying this event

Behaviour:
- Clock and reset: single clock clk. rst_n is asynchronous and active-low.
- Reset values: kbd_nextdata_n=1, evt_valid=0, evt_code/ascii=0, evt_ext/break=0, evt_mods=0. Also cleared: FSM=IDLE, pending ext/brk flags, skip counter, modifier and held flags.
- Pop rule: pop only in IDLE, with kbd_ready=1 and out_free = (!evt_valid || evt_ready). A pop drives kbd_nextdata_n=0 for exactly that cycle and registers kbd_scan_code.
- Bubble: the FSM goes to WAIT for one cycle after every pop, because the receiver updates r_ptr/ready one cycle late. No back-to-back pops. Max rate is 1 byte per 2 cycles.
- Byte classification happens in the pop cycle, and any event register load happens on that edge. Latency from pop to evt_valid=1 is 1 cycle.
- FSM states: IDLE, WAIT, SKIP.
  - E0 -> set ext flag. No event.
  - F0 -> set brk flag. No event.
  - E1 -> clear flags, load skip_cnt=E1_SKIP_LEN, enter SKIP. SKIP still pops with the same bubble and decrements per byte; at 0 it returns to IDLE. No event for Pause.
  - FA, AA, EE, FE, 00, FF with no pending flag -> dropped silently.
  - Any other byte -> event {code, ext, brk}, then clear both flags.
- Output handshake: evt_valid rises when an event loads. It falls on the edge where evt_valid&evt_ready=1, unless a new event loads on that same edge (then it stays 1 with new data). Output fields are stable while valid&&!ready.
- Back-pressure: while the output is occupied and not accepted, no pops occur and the receiver FIFO absorbs bytes.
- Modifiers are updated together with the event load:
  - shift = lshift(12)|rshift(59), each tracked separately.
  - ctrl = 14, or E0 14.
  - alt = 11, or E0 11.
  - caps_lock toggles on make of 58 only if caps_held=0. caps_held is set on make and cleared on break, so typematic repeat does not re-toggle.
- ASCII (make only, ext=0):
  - letters: upper case if shift^caps_lock.
  - digits/punctuation: shifted glyph if shift.
  - 5A -> 0x0D, 66 -> 0x08, 29 -> 0x20, 0D -> 0x09, 76 -> 0x1B.
  - ext: E0 4A -> '/', E0 5A -> 0x0D.
  - all others 0x00. Break events always 0x00.
- Simultaneous events: a prefix byte with evt_ready high does not affect the held event. Pending flags survive output stalls.
- Reset mid-operation: asynchronous clear regardless of state. Bytes left in the receiver FIFO are decoded fresh after reset, with no carried prefix.

Decomposition:
- Shared package holds:
  - byte constants: PS2_PFX_EXT=E0, PS2_PFX_BRK=F0, PS2_PFX_PAUSE=E1, PS2_ACK=FA, PS2_BAT=AA.
  - modifier code constants.
  - FSM state enum.
  - bit positions of evt_mods.
- One combinational sub-module, ps2_ascii_map. Inputs code, ext, shift, caps; output ascii. Instantiated only when ASCII_EN=1.

Test Plan:
- Push 1C -> one event code=1C ext=0 break=0 ascii=0x61 mods=0. kbd_nextdata_n low exactly 1 cycle; evt_valid 1 cycle after pop.
- Push 12,1C,F0,1C,F0,12 with evt_ready=1 -> 4 events. 'A' is 0x41 with mods=0001. Breaks have ascii=0. Final mods=0. Pops spaced ≥2 cycles.
- Push E0,F0,75 -> single event code=75 ext=1 break=1 ascii=0.
- Push 58,58,F0,58,1C -> caps toggles once (mods=1000). 1C gives 0x41.
- Hold evt_ready=0 with 3 events queued -> evt_valid stays 1, data stable, no pops. Release -> remaining events in order.
- Push E1,14,77,E1,F0,14,F0,77,1C -> only event 1C. Separately, assert rst_n=0 after E0 -> next 1C has ext=0.

Source files
------------

// File: rtl/ps2_scancode_decoder_pkg.sv
// Shared constants for the PS/2 Set-2 scan-code decoder: prefix bytes,
// modifier key codes, FSM encoding and evt_mods bit positions.
package ps2_scancode_decoder_pkg;

  localparam logic [7:0] PS2_PFX_EXT   = 8'hE0;
  localparam logic [7:0] PS2_PFX_BRK   = 8'hF0;
  localparam logic [7:0] PS2_PFX_PAUSE = 8'hE1;
  localparam logic [7:0] PS2_ACK       = 8'hFA;
  localparam logic [7:0] PS2_BAT       = 8'hAA;
  localparam logic [7:0] PS2_ECHO      = 8'hEE;
  localparam logic [7:0] PS2_RESEND    = 8'hFE;
  localparam logic [7:0] PS2_ERR0      = 8'h00;
  localparam logic [7:0] PS2_ERR1      = 8'hFF;

  localparam logic [7:0] KEY_LSHIFT = 8'h12;
  localparam logic [7:0] KEY_RSHIFT = 8'h59;
  localparam logic [7:0] KEY_CTRL   = 8'h14;
  localparam logic [7:0] KEY_ALT    = 8'h11;
  localparam logic [7:0] KEY_CAPS   = 8'h58;

  localparam logic [7:0] ASCII_CR = 8'h0D;

  typedef logic [1:0] ps2_state_t;
  localparam ps2_state_t ST_IDLE = 2'd0;
  localparam ps2_state_t ST_WAIT = 2'd1;
  localparam ps2_state_t ST_SKIP = 2'd2;

  typedef logic [3:0] ps2_mods_t;
  localparam int MOD_SHIFT = 0;
  localparam int MOD_CTRL  = 1;
  localparam int MOD_ALT   = 2;
  localparam int MOD_CAPS  = 3;

endpackage

// File: rtl/ps2_scancode_decoder_if.sv
// Decoded key-event bus between the decoder (master) and the MMIO register (slave).
// Handshake: an event transfers on every rising clk edge where evt_valid && evt_ready;
// the master holds all evt_* fields stable while evt_valid && !evt_ready.
interface ps2_scancode_decoder_if;
  import ps2_scancode_decoder_pkg::*;

  logic       evt_valid;
  logic       evt_ready;
  logic [7:0] evt_code;
  logic       evt_ext;
  logic       evt_break;
  logic [7:0] evt_ascii;
  ps2_mods_t  evt_mods;
  ps2_state_t dbg_state;

  modport master (
    output evt_valid, evt_code, evt_ext, evt_break, evt_ascii, evt_mods, dbg_state,
    input  evt_ready
  );

  modport slave (
    input  evt_valid, evt_code, evt_ext, evt_break, evt_ascii, evt_mods, dbg_state,
    output evt_ready
  );

endinterface

// File: rtl/ps2_scancode_decoder_ascii_map.sv
// Combinational Set-2 scan code to ASCII translation for make events.
module ps2_ascii_map
  import ps2_scancode_decoder_pkg::*;
(
  input  logic [7:0] code,
  input  logic       ext,
  input  logic       shift,
  input  logic       caps,
  output logic [7:0] ascii
);

  logic [7:0] base;
  logic [7:0] shifted;
  logic       is_letter;

  always_comb begin
    base = 8'h00;
    if (ext) begin
      case (code)
        8'h4A:   base = 8'h2F;
        8'h5A:   base = ASCII_CR;
        default: base = 8'h00;
      endcase
    end else begin
      case (code)
        8'h1C: base = "a";  8'h32: base = "b";  8'h21: base = "c";  8'h23: base = "d";
        8'h24: base = "e";  8'h2B: base = "f";  8'h34: base = "g";  8'h33: base = "h";
        8'h43: base = "i";  8'h3B: base = "j";  8'h42: base = "k";  8'h4B: base = "l";
        8'h3A: base = "m";  8'h31: base = "n";  8'h44: base = "o";  8'h4D: base = "p";
        8'h15: base = "q";  8'h2D: base = "r";  8'h1B: base = "s";  8'h2C: base = "t";
        8'h3C: base = "u";  8'h2A: base = "v";  8'h1D: base = "w";  8'h22: base = "x";
        8'h35: base = "y";  8'h1A: base = "z";
        8'h45: base = "0";  8'h16: base = "1";  8'h1E: base = "2";  8'h26: base = "3";
        8'h25: base = "4";  8'h2E: base = "5";  8'h36: base = "6";  8'h3D: base = "7";
        8'h3E: base = "8";  8'h46: base = "9";
        8'h0E: base = 8'h60; 8'h4E: base = 8'h2D; 8'h55: base = 8'h3D; 8'h54: base = 8'h5B;
        8'h5B: base = 8'h5D; 8'h5D: base = 8'h5C; 8'h4C: base = 8'h3B; 8'h52: base = 8'h27;
        8'h41: base = 8'h2C; 8'h49: base = 8'h2E; 8'h4A: base = 8'h2F;
        8'h5A: base = ASCII_CR; 8'h66: base = 8'h08; 8'h29: base = 8'h20;
        8'h0D: base = 8'h09;    8'h76: base = 8'h1B;
        default: base = 8'h00;
      endcase
    end

    // Keys without a shifted glyph keep their base value under shift.
    shifted = base;
    if (!ext) begin
      case (code)
        8'h45: shifted = 8'h29; 8'h16: shifted = 8'h21; 8'h1E: shifted = 8'h40; 8'h26: shifted = 8'h23;
        8'h25: shifted = 8'h24; 8'h2E: shifted = 8'h25; 8'h36: shifted = 8'h5E; 8'h3D: shifted = 8'h26;
        8'h3E: shifted = 8'h2A; 8'h46: shifted = 8'h28;
        8'h0E: shifted = 8'h7E; 8'h4E: shifted = 8'h5F; 8'h55: shifted = 8'h2B; 8'h54: shifted = 8'h7B;
        8'h5B: shifted = 8'h7D; 8'h5D: shifted = 8'h7C; 8'h4C: shifted = 8'h3A; 8'h52: shifted = 8'h22;
        8'h41: shifted = 8'h3C; 8'h49: shifted = 8'h3E; 8'h4A: shifted = 8'h3F;
        default: shifted = base;
      endcase
    end

    is_letter = !ext && (base >= "a") && (base <= "z");
    if (is_letter) ascii = (shift ^ caps) ? (base - 8'h20) : base;
    else           ascii = shift ? shifted : base;
  end

endmodule

// File: rtl/ps2_scancode_decoder.sv
// Pops Set-2 bytes from the PS/2 receiver FIFO, strips E0/F0/E1 prefixes,
// tracks modifiers and presents one key event per make/break on evt_if.
module ps2_scancode_decoder
  import ps2_scancode_decoder_pkg::*;
#(
  parameter int E1_SKIP_LEN = 7,
  parameter bit ASCII_EN    = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [7:0]             kbd_scan_code,
  input  logic                   kbd_ready,
  output logic                   kbd_nextdata_n,
  ps2_scancode_decoder_if.master evt_if
);

  localparam int SKW = (E1_SKIP_LEN < 2) ? 1 : $clog2(E1_SKIP_LEN + 1);

  ps2_state_t     state_q, state_d;
  logic [SKW-1:0] skip_q, skip_d;
  logic           ext_q, ext_d, brk_q, brk_d;
  logic           lsh_q, lsh_d, rsh_q, rsh_d;
  logic           lctl_q, lctl_d, rctl_q, rctl_d;
  logic           lalt_q, lalt_d, ralt_q, ralt_d;
  logic           caps_q, caps_d, caps_held_q, caps_held_d;
  logic           valid_q, valid_d;
  logic [7:0]     code_q, code_d, ascii_q, ascii_d;
  logic           evt_ext_q, evt_ext_d, evt_brk_q, evt_brk_d;
  ps2_mods_t      mods_q, mods_d;
  logic           out_free, pop, is_drop, load;
  logic [7:0]     map_ascii;

  generate
    if (ASCII_EN) begin : g_ascii
      ps2_ascii_map u_ascii_map (
        .code  (kbd_scan_code),
        .ext   (ext_q),
        .shift (lsh_q | rsh_q),
        .caps  (caps_q),
        .ascii (map_ascii)
      );
    end else begin : g_no_ascii
      assign map_ascii = 8'h00;
    end
  endgenerate

  // rst_n gates the strobe so the receiver never sees a pop while we are held in reset.
  assign out_free       = !valid_q || evt_if.evt_ready;
  assign pop            = rst_n && kbd_ready &&
                          (((state_q == ST_IDLE) && out_free) || (state_q == ST_SKIP));
  assign kbd_nextdata_n = !pop;
  assign is_drop        = kbd_scan_code inside {PS2_ACK, PS2_BAT, PS2_ECHO,
                                                PS2_RESEND, PS2_ERR0, PS2_ERR1};

  always_comb begin
    state_d     = state_q;
    skip_d      = skip_q;
    ext_d       = ext_q;
    brk_d       = brk_q;
    lsh_d       = lsh_q;
    rsh_d       = rsh_q;
    lctl_d      = lctl_q;
    rctl_d      = rctl_q;
    lalt_d      = lalt_q;
    ralt_d      = ralt_q;
    caps_d      = caps_q;
    caps_held_d = caps_held_q;
    valid_d     = valid_q && !evt_if.evt_ready;
    code_d      = code_q;
    ascii_d     = ascii_q;
    evt_ext_d   = evt_ext_q;
    evt_brk_d   = evt_brk_q;
    mods_d      = mods_q;
    load        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (pop) begin
          state_d = ST_WAIT;
          if (kbd_scan_code == PS2_PFX_EXT) begin
            ext_d = 1'b1;
          end else if (kbd_scan_code == PS2_PFX_BRK) begin
            brk_d = 1'b1;
          end else if (kbd_scan_code == PS2_PFX_PAUSE) begin
            ext_d  = 1'b0;
            brk_d  = 1'b0;
            skip_d = SKW'(E1_SKIP_LEN);
          end else if (!(is_drop && !ext_q && !brk_q)) begin
            load  = 1'b1;
            ext_d = 1'b0;
            brk_d = 1'b0;
          end
        end
      end
      // The receiver's head/ready lag the pop by a cycle, so never sample here.
      ST_WAIT: state_d = (skip_q != '0) ? ST_SKIP : ST_IDLE;
      ST_SKIP: begin
        if (pop) begin
          skip_d  = skip_q - SKW'(1);
          state_d = ST_WAIT;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (load) begin
      case (kbd_scan_code)
        KEY_LSHIFT: lsh_d = !brk_q;
        KEY_RSHIFT: rsh_d = !brk_q;
        KEY_CTRL:   if (ext_q) rctl_d = !brk_q; else lctl_d = !brk_q;
        KEY_ALT:    if (ext_q) ralt_d = !brk_q; else lalt_d = !brk_q;
        KEY_CAPS: begin
          if (brk_q) begin
            caps_held_d = 1'b0;
          end else begin
            if (!caps_held_q) caps_d = !caps_q;
            caps_held_d = 1'b1;
          end
        end
        default: ;
      endcase
      valid_d           = 1'b1;
      code_d            = kbd_scan_code;
      evt_ext_d         = ext_q;
      evt_brk_d         = brk_q;
      ascii_d           = brk_q ? 8'h00 : map_ascii;
      mods_d[MOD_SHIFT] = lsh_d | rsh_d;
      mods_d[MOD_CTRL]  = lctl_d | rctl_d;
      mods_d[MOD_ALT]   = lalt_d | ralt_d;
      mods_d[MOD_CAPS]  = caps_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      skip_q      <= '0;
      ext_q       <= 1'b0;
      brk_q       <= 1'b0;
      lsh_q       <= 1'b0;
      rsh_q       <= 1'b0;
      lctl_q      <= 1'b0;
      rctl_q      <= 1'b0;
      lalt_q      <= 1'b0;
      ralt_q      <= 1'b0;
      caps_q      <= 1'b0;
      caps_held_q <= 1'b0;
      valid_q     <= 1'b0;
      code_q      <= 8'h00;
      ascii_q     <= 8'h00;
      evt_ext_q   <= 1'b0;
      evt_brk_q   <= 1'b0;
      mods_q      <= '0;
    end else begin
      state_q     <= state_d;
      skip_q      <= skip_d;
      ext_q       <= ext_d;
      brk_q       <= brk_d;
      lsh_q       <= lsh_d;
      rsh_q       <= rsh_d;
      lctl_q      <= lctl_d;
      rctl_q      <= rctl_d;
      lalt_q      <= lalt_d;
      ralt_q      <= ralt_d;
      caps_q      <= caps_d;
      caps_held_q <= caps_held_d;
      valid_q     <= valid_d;
      code_q      <= code_d;
      ascii_q     <= ascii_d;
      evt_ext_q   <= evt_ext_d;
      evt_brk_q   <= evt_brk_d;
      mods_q      <= mods_d;
    end
  end

  assign evt_if.evt_valid = valid_q;
  assign evt_if.evt_code  = code_q;
  assign evt_if.evt_ext   = evt_ext_q;
  assign evt_if.evt_break = evt_brk_q;
  assign evt_if.evt_ascii = ascii_q;
  assign evt_if.evt_mods  = mods_q;
  assign evt_if.dbg_state = state_q;

endmodule
